// File: rtl/lat_table_loader.sv
// Parallel-to-serial loader for the look-at-table core's REG_STATE input: frame in via valid/ready, MSB first out.
// Optional even-parity trailer bit when LOADER_PARITY_EN is defined.
module lat_table_loader #(
  parameter int WIDTH      = 27,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_en,
  output logic             done,
  output logic [7:0]       frame_cnt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    LAST_DIV = 8'(BIT_CYCLES - 1);

`ifdef LOADER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       div_q, div_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_en_q, ser_en_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
`ifdef LOADER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    div_d       = div_q;
    ser_out_d   = ser_out_q;
    ser_en_d    = ser_en_q;
    done_d      = 1'b0;
    ready_d     = ready_q;
    frame_cnt_d = frame_cnt_q;
`ifdef LOADER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: begin
        ser_out_d = 1'b0;
        ser_en_d  = 1'b0;
        ready_d   = 1'b1;
        if (load_valid && ready_q) begin
          state_d   = SHIFT;
          shift_d   = load_data;
          bit_cnt_d = '0;
          div_d     = 8'd0;
          ser_out_d = load_data[WIDTH-1];
          ser_en_d  = 1'b1;
          ready_d   = 1'b0;
`ifdef LOADER_PARITY_EN
          par_d     = even_parity(load_data);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          ser_out_d = 1'b0;
          ser_en_d  = 1'b0;
          ready_d   = 1'b1;
        end else if (div_q == LAST_DIV) begin
          div_d = 8'd0;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef LOADER_PARITY_EN
            state_d   = PAR;
            ser_out_d = par_q;
`else
            state_d     = IDLE;
            ser_out_d   = 1'b0;
            ser_en_d    = 1'b0;
            ready_d     = 1'b1;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            ser_out_d = shift_q[WIDTH-2];
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
`ifdef LOADER_PARITY_EN
      PAR: begin
        if (abort) begin
          state_d   = IDLE;
          ser_out_d = 1'b0;
          ser_en_d  = 1'b0;
          ready_d   = 1'b1;
        end else if (div_q == LAST_DIV) begin
          state_d     = IDLE;
          div_d       = 8'd0;
          ser_out_d   = 1'b0;
          ser_en_d    = 1'b0;
          ready_d     = 1'b1;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d   = IDLE;
        ser_out_d = 1'b0;
        ser_en_d  = 1'b0;
        ready_d   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      div_q       <= 8'd0;
      ser_out_q   <= 1'b0;
      ser_en_q    <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      frame_cnt_q <= 8'd0;
`ifdef LOADER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      ser_out_q   <= ser_out_d;
      ser_en_q    <= ser_en_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef LOADER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign load_ready = ready_q;
  assign ser_out    = ser_out_q;
  assign ser_en     = ser_en_q;
  assign done       = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_lat_table_loader.sv
// Scoreboard bench for lat_table_loader: one instance with BIT_CYCLES=1, one with BIT_CYCLES=3.
module tb_lat_table_loader;

  localparam int W = 27;
`ifdef LOADER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L1 = 1 * (W + PB) + 1;
  localparam int L3 = 3 * (W + PB) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         valid1, ready1, abort1, out1, en1, done1;
  logic [W-1:0] data1;
  logic [7:0]   cnt1;
  logic         valid3, ready3, abort3, out3, en3, done3;
  logic [W-1:0] data3;
  logic [7:0]   cnt3;

  lat_table_loader #(.WIDTH(W), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .load_valid(valid1), .load_ready(ready1),
    .load_data(data1), .abort(abort1), .ser_out(out1), .ser_en(en1),
    .done(done1), .frame_cnt(cnt1));

  lat_table_loader #(.WIDTH(W), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .load_valid(valid3), .load_ready(ready3),
    .load_data(data3), .abort(abort3), .ser_out(out3), .ser_en(en3),
    .done(done3), .frame_cnt(cnt3));

  int checks = 0;
  int errors = 0;
  logic q1[$];
  logic q3[$];
  logic [7:0] exp_cnt1 = 8'd0;
  logic [7:0] exp_cnt3 = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial-bit scoreboard: every ser_en cycle consumes one expected bit.
  always @(negedge clk) begin
    if (en1 === 1'b1) begin
      check("dut1_bit_expected", {31'b0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) check("dut1_ser_out", {31'b0, out1}, {31'b0, q1.pop_front()});
    end
    if (en3 === 1'b1) begin
      check("dut3_bit_expected", {31'b0, q3.size() != 0}, 32'd1);
      if (q3.size() != 0) check("dut3_ser_out", {31'b0, out3}, {31'b0, q3.pop_front()});
    end
  end

  task automatic push(input int which, input logic [W-1:0] d, input int nbits);
    int bc;
    bc = (which == 1) ? 1 : 3;
    for (int i = 0; i < nbits; i++)
      for (int r = 0; r < bc; r++)
        if (which == 1) q1.push_back(d[W-1-i]); else q3.push_back(d[W-1-i]);
    if (nbits == W && PB == 1)
      for (int r = 0; r < bc; r++)
        if (which == 1) q1.push_back(^d); else q3.push_back(^d);
  endtask

  task automatic send(input int which, input logic [W-1:0] d, input int nbits);
    @(negedge clk);
    push(which, d, nbits);
    if (which == 1) begin valid1 = 1'b1; data1 = d; end
    else begin valid3 = 1'b1; data3 = d; end
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    valid3 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int exp_lat);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < exp_lat + 20) begin
      @(negedge clk);
      n++;
      seen = (which == 1) ? done1 : done3;
    end
    check("done_latency", n, exp_lat);
    if (which == 1) begin
      exp_cnt1 = exp_cnt1 + 8'd1;
      check("dut1_frame_cnt", {24'b0, cnt1}, {24'b0, exp_cnt1});
      check("dut1_ready_in_done", {31'b0, ready1}, 32'd1);
      check("dut1_en_in_done", {31'b0, en1}, 32'd0);
      check("dut1_queue_drained", q1.size(), 32'd0);
    end else begin
      exp_cnt3 = exp_cnt3 + 8'd1;
      check("dut3_frame_cnt", {24'b0, cnt3}, {24'b0, exp_cnt3});
      check("dut3_en_in_done", {31'b0, en3}, 32'd0);
      check("dut3_queue_drained", q3.size(), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    valid1 = 1'b1; data1 = 27'h5A5A5A5; abort1 = 1'b0;
    valid3 = 1'b0; data3 = '0; abort3 = 1'b0;

    // Reset held with load_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, ready1}, 32'd1);
    check("rst_en", {31'b0, en1}, 32'd0);
    check("rst_out", {31'b0, out1}, 32'd0);
    check("rst_cnt", {24'b0, cnt1}, 32'd0);
    check("rst_done", {31'b0, done1}, 32'd0);
    reset = 1'b1;
    valid1 = 1'b0;
    @(negedge clk);
    check("rst_no_accept", {31'b0, en1}, 32'd0);

    // Single frame
    send(1, 27'h5A5A5A5, W);
    wait_done(1, L1);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done1}, 32'd0);

    // Bit stretching
    send(3, 27'h4000001, W);
    wait_done(3, L3);

    // Back-to-back with load_valid held
    @(negedge clk);
    push(1, 27'h7FFFFFF, W);
    valid1 = 1'b1;
    data1 = 27'h7FFFFFF;
    @(posedge clk);
    #1;
    data1 = 27'h0000000;
    wait_done(1, L1);
    push(1, 27'h0000000, W);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    wait_done(1, L1);

    // Abort at bit 10
    send(1, 27'h1234567, 10);
    repeat (10) @(negedge clk);
    abort1 = 1'b1;
    @(posedge clk);
    #1;
    abort1 = 1'b0;
    @(negedge clk);
    check("abort_en", {31'b0, en1}, 32'd0);
    check("abort_out", {31'b0, out1}, 32'd0);
    check("abort_ready", {31'b0, ready1}, 32'd1);
    repeat (3) @(negedge clk);
    check("abort_no_done", {31'b0, done1}, 32'd0);
    check("abort_cnt", {24'b0, cnt1}, {24'b0, exp_cnt1});
    check("abort_queue", q1.size(), 32'd0);
    send(1, 27'h2AAAAAA, W);
    wait_done(1, L1);

    // Reset at bit 5
    send(1, 27'h3C3C3C3, 5);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    exp_cnt1 = 8'd0;
    exp_cnt3 = 8'd0;
    check("mid_rst_en", {31'b0, en1}, 32'd0);
    check("mid_rst_out", {31'b0, out1}, 32'd0);
    check("mid_rst_done", {31'b0, done1}, 32'd0);
    check("mid_rst_ready", {31'b0, ready1}, 32'd1);
    check("mid_rst_cnt", {24'b0, cnt1}, 32'd0);
    check("mid_rst_cnt3", {24'b0, cnt3}, 32'd0);
    check("mid_rst_queue", q1.size(), 32'd0);

    // Counter wrap over 256 frames
    for (int f = 0; f < 256; f++) begin
      send(1, W'($urandom), W);
      wait_done(1, L1);
    end
    check("wrap_cnt", {24'b0, cnt1}, 32'd0);

    // Frame with odd popcount (parity trailer is 1 when enabled)
    send(1, 27'h0000007, W);
    wait_done(1, L1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lat_table_loader.md
# lat_table_loader

Upstream serializer for the look-at-table FSM core. Accepts one parallel configuration frame (five 5-bit jump states plus clock-select bits) through a valid/ready handshake. Shifts the frame MSB-first onto the single-bit `REG_STATE` line that feeds the core's serial-in/parallel-out table register. Provides a bit-qualifier, an end-of-frame pulse, an abort path and a completed-frame counter so a host or test controller can reprogram the table at run time.

## Interface
Parameters:
- `WIDTH`, 27, frame length in bits (25 state bits + 2 clock-select bits).
- `BIT_CYCLES`, 1, clocks each bit is held on `ser_out`; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `load_valid`  in  1  host presents a frame.
- `load_ready`  out  1  loader can accept a frame.
- `load_data`  in  WIDTH  frame, bit WIDTH-1 sent first.
- `abort`  in  1  synchronous cancel of the frame in flight.
- `ser_out`  out  1  serial data to the core's `REG_STATE` input.
- `ser_en`  out  1  high while `ser_out` carries a valid bit.
- `done`  out  1  one-cycle pulse after the last bit of a frame (parity bit included when enabled).
- `frame_cnt`  out  8  count of completed frames.

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with the parity feature).
- Reset (`reset`=0 at an edge):
  - State returns to IDLE and the shift register clears.
  - Outputs: `ser_out`=0, `ser_en`=0, `done`=0, `load_ready`=1, `frame_cnt`=0.
  - Reset overrides everything, including a frame in flight.
- IDLE:
  - `load_ready`=1, `ser_out`=0, `ser_en`=0.
  - When `load_valid` and `load_ready` are both 1, the frame is accepted. The loader captures `load_data`, clears the bit counter and divider, and moves to SHIFT.
- SHIFT:
  - `ser_out` is the registered MSB of the shift register; `ser_en`=1; `load_ready`=0.
  - Each bit is held for BIT_CYCLES clocks, then the register shifts left by one.
  - After bit 0 has been held for BIT_CYCLES clocks:
    - Without parity, the loader returns to IDLE and raises `done` in that IDLE cycle.
    - With parity, the loader moves to PAR.
- `frame_cnt` increments in the same cycle `done` is asserted; it wraps from 255 to 0.
- `abort`:
  - Sampled high in SHIFT or PAR, it forces IDLE at that edge.
  - `ser_out` and `ser_en` go to 0. No `done` pulse, and `frame_cnt` is unchanged.
  - `abort` in IDLE has no effect. If `abort` and an accept coincide in IDLE, the accept wins.
- `load_valid` while busy is ignored. `load_data` is sampled only on the accept edge.

## Timing
- Accept at edge k: the first bit appears on `ser_out` with `ser_en`=1 during cycles k+1 .. k+BIT_CYCLES.
- Frame duration is WIDTH*BIT_CYCLES cycles, plus BIT_CYCLES more with parity.
- `done` is high for exactly one cycle, the cycle right after the last serial bit. `load_ready`=1 in that same cycle.
- A back-to-back accept in the `done` cycle is legal. The minimum gap between frames is one idle cycle, during which `ser_en`=0.
- `ser_out` and `ser_en` change only on clock edges, so the core's shift register can sample them on the same clock.

## Configuration
- `LOADER_PARITY_EN` defined:
  - After bit 0, the PAR state drives one extra bit for BIT_CYCLES clocks.
  - The extra bit is the XOR of all WIDTH bits of the accepted frame (even parity), with `ser_en`=1 during it.
  - `done` follows the parity bit.
- `LOADER_PARITY_EN` undefined: the PAR state and parity logic are absent, and exactly WIDTH bits are sent.

## Test plan
- Reset check: hold `reset`=0 for 2 cycles with `load_valid`=1 -> `load_ready`=1, `ser_en`=0, `ser_out`=0, `frame_cnt`=0, and no frame is accepted.
- Single frame, BIT_CYCLES=1, `load_data`=27'h5A5A5A5, accepted at edge k:
  - `ser_out` over cycles k+1..k+27 equals the bits 26 down to 0 of 27'h5A5A5A5.
  - `done`=1 at k+28 only, and `frame_cnt`=1.
- Bit stretching, BIT_CYCLES=3, `load_data`=27'h4000001 -> `ser_out`=1 for cycles k+1..k+3, 0 for k+4..k+78, 1 for k+79..k+81, `done` at k+82.
- Back-to-back frames: hold `load_valid` continuously with frames 27'h7FFFFFF then 27'h0000000 -> second accept in the `done` cycle, one `ser_en`=0 cycle between frames, `frame_cnt`=2.
- Abort and reset mid-frame:
  - `abort`=1 at bit 10 -> IDLE next cycle, no `done`, `frame_cnt` unchanged, next frame sent intact.
  - `reset`=0 at bit 5 -> all outputs at their reset values next cycle.
- Counter wrap, plus parity with `LOADER_PARITY_EN`:
  - 256 completed frames -> `frame_cnt` returns to 0.
  - Frame 27'h0000007 -> a 28th bit equal to 1 is sent.
